// File: rtl/glyph_pkg.sv
//------------------------------------------------------------------------------
// Module   : glyph_pkg
// Purpose  : Shared definitions for the seven-segment glyph drawer: segment
//            indices in draw order, FSM state encoding and common letter masks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package glyph_pkg;

  // Segment indices; the drawer walks them in ascending order.
  localparam logic [2:0] SEG_TOP  = 3'd0;
  localparam logic [2:0] SEG_UR   = 3'd1;
  localparam logic [2:0] SEG_LR   = 3'd2;
  localparam logic [2:0] SEG_BOT  = 3'd3;
  localparam logic [2:0] SEG_LL   = 3'd4;
  localparam logic [2:0] SEG_UL   = 3'd5;
  localparam logic [2:0] SEG_MID  = 3'd6;
  // One past the last segment: marks "all segments finished".
  localparam logic [2:0] SEG_DONE = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2
  } state_t;

  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_H = 7'h76;

endpackage

`default_nettype wire

// File: rtl/glyph_seg_offset.sv
//------------------------------------------------------------------------------
// Module   : glyph_seg_offset
// Purpose  : Combinational map from (segment index, pixel index) to the pixel
//            offset (dx, dy) relative to the glyph's top-left origin.
//            L = SEG_LEN-1; the glyph is (L+1) wide and (2L+1) tall.
// Ports    : seg [2:0]        segment index (SEG_DONE gives a zero offset)
//            idx [CNT_W-1:0]  pixel index within the segment, 0..L
//            dx  [X_W-1:0]    x offset
//            dy  [Y_W-1:0]    y offset
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module glyph_seg_offset
  import glyph_pkg::*;
#(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int SEG_LEN = 16,
  parameter int CNT_W   = 4
) (
  input  logic [2:0]       seg,
  input  logic [CNT_W-1:0] idx,
  output logic [X_W-1:0]   dx,
  output logic [Y_W-1:0]   dy
);

  localparam int L = SEG_LEN - 1;
  localparam logic [X_W-1:0] LX  = X_W'(L);
  localparam logic [Y_W-1:0] LY  = Y_W'(L);
  localparam logic [Y_W-1:0] L2Y = Y_W'(2 * L);

  // Offsets are formed at the final coordinate widths; any overflow simply
  // wraps, matching the modular coordinate arithmetic of the drawer.
  logic [X_W-1:0] ix;
  logic [Y_W-1:0] iy;

  always_comb begin
    ix = X_W'(idx);
    iy = Y_W'(idx);
    dx = '0;
    dy = '0;
    case (seg)
      SEG_TOP: begin dx = ix; dy = '0;       end
      SEG_UR:  begin dx = LX; dy = iy;       end
      SEG_LR:  begin dx = LX; dy = LY + iy;  end
      SEG_BOT: begin dx = ix; dy = L2Y;      end
      SEG_LL:  begin dx = '0; dy = LY + iy;  end
      SEG_UL:  begin dx = '0; dy = iy;       end
      SEG_MID: begin dx = ix; dy = LY;       end
      default: begin dx = '0; dy = '0;       end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/glyph_seg_drawer.sv
//------------------------------------------------------------------------------
// Module   : glyph_seg_drawer
// Purpose  : Draws a seven-segment-style glyph at a run-time origin, one pixel
//            per clock, for the VGA adapter. Start/busy/done handshake lets a
//            top level sequence glyphs back to back.
// Ports    : clk        system clock
//            resetn     asynchronous active-low reset
//            start      request, sampled only in IDLE
//            x0, y0     glyph origin (top-left), latched on accept
//            seg_mask   segment enables (bit0 top .. bit6 middle), latched
//            colour_in  draw colour, latched
//            out_x/out_y/out_colour/plot  registered pixel stream
//            busy       high from accept until done
//            done       one-cycle completion pulse
// Options  : GLYPH_ERASE_EN - when defined, each glyph is preceded by an
//            erase pass drawing all seven segments in BG_COLOUR.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module glyph_seg_drawer
  import glyph_pkg::*;
#(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COL_W     = 3,
  parameter int SEG_LEN   = 16,
  parameter int BG_COLOUR = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [6:0]       seg_mask,
  input  logic [COL_W-1:0] colour_in,
  output logic [X_W-1:0]   out_x,
  output logic [Y_W-1:0]   out_y,
  output logic [COL_W-1:0] out_colour,
  output logic             plot,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(SEG_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEG_LEN - 1);

  state_t           state_q, state_d;
  logic [2:0]       seg_q, seg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   x0_q, x0_d;
  logic [Y_W-1:0]   y0_q, y0_d;
  logic [6:0]       mask_q, mask_d;
  logic [COL_W-1:0] colour_q, colour_d;

  logic [X_W-1:0]   x_d;
  logic [Y_W-1:0]   y_d;
  logic [COL_W-1:0] col_d;
  logic             plot_d, busy_d, done_d;

  logic [X_W-1:0]   dx;
  logic [Y_W-1:0]   dy;

  glyph_seg_offset #(
    .X_W     (X_W),
    .Y_W     (Y_W),
    .SEG_LEN (SEG_LEN),
    .CNT_W   (CNT_W)
  ) u_offset (
    .seg (seg_q),
    .idx (cnt_q),
    .dx  (dx),
    .dy  (dy)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      seg_q      <= '0;
      cnt_q      <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      mask_q     <= '0;
      colour_q   <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      cnt_q      <= cnt_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      mask_q     <= mask_d;
      colour_q   <= colour_d;
      out_x      <= x_d;
      out_y      <= y_d;
      out_colour <= col_d;
      plot       <= plot_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    cnt_d    = cnt_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    mask_d   = mask_q;
    colour_d = colour_q;
    // Coordinates and colour hold when no pixel is emitted.
    x_d      = out_x;
    y_d      = out_y;
    col_d    = out_colour;
    plot_d   = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Also reached in the done cycle, so a start held there is accepted
        // with no gap between glyphs.
        if (start) begin
          x0_d     = x0;
          y0_d     = y0;
          mask_d   = seg_mask;
          colour_d = colour_in;
          busy_d   = 1'b1;
          seg_d    = SEG_TOP;
          cnt_d    = '0;
`ifdef GLYPH_ERASE_EN
          state_d  = ERASE;
`else
          state_d  = DRAW;
`endif
        end
      end

      ERASE: begin
        // Every segment is painted in the background colour, ignoring mask.
        plot_d = 1'b1;
        x_d    = x0_q + dx;
        y_d    = y0_q + dy;
        col_d  = COL_W'(BG_COLOUR);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (seg_q == SEG_MID) begin
            seg_d   = SEG_TOP;
            state_d = DRAW;
          end else begin
            seg_d = seg_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DRAW: begin
        if (seg_q == SEG_DONE) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          seg_d   = SEG_TOP;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (mask_q[seg_q]) begin
          plot_d = 1'b1;
          x_d    = x0_q + dx;
          y_d    = y0_q + dy;
          col_d  = colour_q;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            seg_d = seg_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Disabled segment costs a single idle cycle.
          seg_d = seg_q + 3'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: doc/glyph_seg_drawer.md
Name: glyph_seg_drawer

Overview:
Parametrised successor to the single-letter VGA drawers. It draws any seven-segment-style glyph (F, E, H, digits, and so on) at a run-time origin. The glyph is selected by a 7-bit segment mask. Output is one pixel per clock as (x, y, colour, plot) for the VGA adapter, with a start/busy/done handshake so the Morse decoder top level can sequence letters.

Parameters:
X_W, 8, width of x coordinate
Y_W, 7, width of y coordinate
COL_W, 3, colour width
SEG_LEN, 16, pixels per segment (minimum 2)
BG_COLOUR, 0, colour used by the erase pass

Ports:
clk  in  1  system clock, 50 MHz
resetn  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
x0  in  X_W  glyph origin x (top-left); latched on accepted start
y0  in  Y_W  glyph origin y; latched on accepted start
seg_mask  in  7  segment enables; latched on accepted start
colour_in  in  COL_W  draw colour; latched on accepted start
out_x  out  X_W  pixel x
out_y  out  Y_W  pixel y
out_colour  out  COL_W  pixel colour
plot  out  1  pixel valid this cycle
busy  out  1  high from accept until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, resetn=0): state IDLE; seg index s=0; count i=0; out_x=0, out_y=0, out_colour=0, plot=0, busy=0, done=0.
- All outputs are registered.
- Segment bits: 0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle. Drawn in bit order 0..6. Let L=SEG_LEN-1.
- Pixel offsets for i=0..L:
  - top (i,0); UR (L,i); LR (L,L+i); bottom (i,2L)
  - LL (0,L+i); UL (0,i); middle (i,L)
- Coordinate arithmetic: out_x=(x0+dx) mod 2^X_W and out_y=(y0+dy) mod 2^Y_W. No clipping; wrap is by truncation.
- IDLE: start=1 at edge k latches the inputs, sets busy<=1 and goes to DRAW with s=0, i=0. The first pixel is visible after edge k+1.
- DRAW, enabled segment: each cycle registers one pixel with plot=1 and out_colour=latched colour, then i++. When i==L: i<=0, s++.
- DRAW, disabled segment: one cycle with plot=0, s++.
- DRAW cycle count = N*SEG_LEN + (7-N), where N = popcount(mask).
- After segment 6 completes, at the next edge: plot<=0, done<=1, busy<=0, state IDLE.
- done lasts exactly one cycle. A start sampled in that same cycle is accepted, giving back-to-back glyphs with no gap.
- start while busy is ignored, and latched inputs do not change mid-glyph.
- mask=0: 7 cycles with plot=0, then done.
- Reset mid-glyph: immediate return to reset values with no done pulse.
- out_x/out_y hold their last value when plot=0.

Optional Feature:
GLYPH_ERASE_EN.
- Defined: every accepted start first runs an erase pass. All 7 segments are drawn with out_colour=BG_COLOUR regardless of mask (7*SEG_LEN plot cycles), then the normal masked pass follows. busy stays high throughout and done is raised only after the masked pass.
- Undefined: no erase pass; BG_COLOUR is unused; timing is exactly as above.

Decomposition:
- Package glyph_pkg holds:
  - segment index constants SEG_TOP..SEG_MID
  - state encoding IDLE/ERASE/DRAW
  - common glyph masks: GLYPH_F=7'h71, GLYPH_E=7'h79, GLYPH_H=7'h76
- Sub-module glyph_seg_offset: combinational, maps (s, i) to (dx, dy). Instantiated once.

Test Plan:
- SEG_LEN=4, x0=10, y0=5, mask=7'h01, colour=3'b100, pulse start → plots (10,5)(11,5)(12,5)(13,5); 10 DRAW cycles; single done; busy falls with done.
- SEG_LEN=4, mask=GLYPH_F → 16 plots, including UL (10,5..8), LL (10,8..11) and middle (10..13,8); total DRAW 19 cycles.
- x0=254, SEG_LEN=4, mask=7'h01 → x sequence 254, 255, 0, 1 at y0.
- start re-pulsed mid-glyph with different x0 → ignored, pixel stream unchanged. start held during the done cycle → second glyph's first plot two edges later.
- resetn low during segment 3 → all outputs 0 asynchronously, no done. After release, a new start draws correctly.
- With GLYPH_ERASE_EN, mask=7'h01, SEG_LEN=4 → 28 plots with colour 0, then 4 plots in colour_in, then done.
